// File: rtl/cpu_control.sv
// LC-3b multicycle control unit: Moore FSM sequencing fetch, decode and execute,
// with all datapath and memory controls held in output registers.
module cpu_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       branch_enable,
  input  logic       imm5_enable,
  input  logic       offset11_enable,
  input  logic       mem_resp,
  output logic       load_pc,
  output logic       load_ir,
  output logic       load_regfile,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_cc,
  output logic [1:0] pcmux_sel,
  output logic [1:0] alumux_sel,
  output logic [1:0] regfilemux_sel,
  output logic       storemux_sel,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic       pcoffsetmux_sel,
  output logic       destmux_sel,
  output logic [2:0] aluop,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_byte_enable
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_AND  = 3'd1;
  localparam logic [2:0] ALU_NOT  = 3'd2;
  localparam logic [2:0] ALU_PASS = 3'd3;

  typedef enum logic [4:0] {
    FETCH1, FETCH2, FETCH3, DECODE, S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKEN,
    S_CALC_ADDR, S_LDR1, S_LDR2, S_STR1, S_STR2, S_JMP, S_JSR, S_LEA
  } state_t;

  typedef struct packed {
    logic       load_pc;
    logic       load_ir;
    logic       load_regfile;
    logic       load_mar;
    logic       load_mdr;
    logic       load_cc;
    logic [1:0] pcmux_sel;
    logic [1:0] alumux_sel;
    logic [1:0] regfilemux_sel;
    logic       storemux_sel;
    logic       marmux_sel;
    logic       mdrmux_sel;
    logic       pcoffsetmux_sel;
    logic       destmux_sel;
    logic [2:0] aluop;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
  } ctrl_t;

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;

  // Control word for a state; registered on entry so outputs are glitch-free.
  function automatic ctrl_t ctrl_of(input state_t s, input logic imm5, input logic off11);
    ctrl_t c;
    c                 = '0;
    c.aluop           = ALU_ADD;
    c.mem_byte_enable = 2'b11;
    case (s)
      FETCH1:      begin c.marmux_sel = 1'b1; c.load_mar = 1'b1; c.load_pc = 1'b1; end
      FETCH2:      begin c.mem_read = 1'b1; c.mdrmux_sel = 1'b1; c.load_mdr = 1'b1; end
      FETCH3:      c.load_ir = 1'b1;
      S_ADD, S_AND: begin
        c.aluop        = (s == S_AND) ? ALU_AND : ALU_ADD;
        c.alumux_sel   = imm5 ? 2'b10 : 2'b00;
        c.load_regfile = 1'b1;
        c.load_cc      = 1'b1;
      end
      S_NOT:       begin c.aluop = ALU_NOT; c.load_regfile = 1'b1; c.load_cc = 1'b1; end
      S_BR_TAKEN:  begin c.pcmux_sel = 2'b01; c.load_pc = 1'b1; end
      S_CALC_ADDR: begin c.alumux_sel = 2'b01; c.load_mar = 1'b1; end
      S_LDR1:      begin c.mem_read = 1'b1; c.mdrmux_sel = 1'b1; c.load_mdr = 1'b1; end
      S_LDR2:      begin c.regfilemux_sel = 2'b01; c.load_regfile = 1'b1; c.load_cc = 1'b1; end
      S_STR1:      begin c.storemux_sel = 1'b1; c.aluop = ALU_PASS; c.load_mdr = 1'b1; end
      S_STR2:      c.mem_write = 1'b1;
      S_JMP:       begin c.pcmux_sel = 2'b10; c.load_pc = 1'b1; end
      S_JSR: begin
        c.destmux_sel     = 1'b1;
        c.regfilemux_sel  = 2'b11;
        c.load_regfile    = 1'b1;
        c.load_pc         = 1'b1;
        c.pcmux_sel       = off11 ? 2'b01 : 2'b10;
        c.pcoffsetmux_sel = off11;
      end
      S_LEA:       begin c.regfilemux_sel = 2'b10; c.load_regfile = 1'b1; c.load_cc = 1'b1; end
      default:     ;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH1:      w_next = FETCH2;
      FETCH2:      if (mem_resp) w_next = FETCH3;
      FETCH3:      w_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_ADD:         w_next = S_ADD;
          OP_AND:         w_next = S_AND;
          OP_NOT:         w_next = S_NOT;
          OP_BR:          w_next = S_BR;
          OP_LDR, OP_STR: w_next = S_CALC_ADDR;
          OP_JMP:         w_next = S_JMP;
          OP_JSR:         w_next = S_JSR;
          OP_LEA:         w_next = S_LEA;
          default:        w_next = FETCH1;
        endcase
      end
      S_BR:        w_next = branch_enable ? S_BR_TAKEN : FETCH1;
      S_CALC_ADDR: w_next = (opcode == OP_STR) ? S_STR1 : S_LDR1;
      S_LDR1:      if (mem_resp) w_next = S_LDR2;
      S_STR1:      w_next = S_STR2;
      S_STR2:      if (mem_resp) w_next = FETCH1;
      default:     w_next = FETCH1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH1;
      r_ctrl  <= ctrl_of(FETCH1, 1'b0, 1'b0);
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_of(w_next, imm5_enable, offset11_enable);
    end
  end

  assign load_pc         = r_ctrl.load_pc;
  assign load_ir         = r_ctrl.load_ir;
  assign load_regfile    = r_ctrl.load_regfile;
  assign load_mar        = r_ctrl.load_mar;
  assign load_mdr        = r_ctrl.load_mdr;
  assign load_cc         = r_ctrl.load_cc;
  assign pcmux_sel       = r_ctrl.pcmux_sel;
  assign alumux_sel      = r_ctrl.alumux_sel;
  assign regfilemux_sel  = r_ctrl.regfilemux_sel;
  assign storemux_sel    = r_ctrl.storemux_sel;
  assign marmux_sel      = r_ctrl.marmux_sel;
  assign mdrmux_sel      = r_ctrl.mdrmux_sel;
  assign pcoffsetmux_sel = r_ctrl.pcoffsetmux_sel;
  assign destmux_sel     = r_ctrl.destmux_sel;
  assign aluop           = r_ctrl.aluop;
  assign mem_read        = r_ctrl.mem_read;
  assign mem_write       = r_ctrl.mem_write;
  assign mem_byte_enable = r_ctrl.mem_byte_enable;

endmodule
